// File: rtl/time_pkg.sv
// Shared types and constants for the front-panel time-set controller.
package time_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEditHr,
    StEditMin,
    StEditSec,
    StCommit
  } state_e;

  typedef enum logic [1:0] {
    FieldHr   = 2'd0,
    FieldMin  = 2'd1,
    FieldSec  = 2'd2,
    FieldNone = 2'd3
  } field_e;

  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Packing is {H1,H0,M1,M0,S1,S0}; each field starts at its units digit.
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned HR_LSB  = 16;
  localparam int unsigned MIN_LSB = 8;
  localparam int unsigned SEC_LSB = 0;

  function automatic field_e state_field(state_e s);
    unique case (s)
      StEditHr:  return FieldHr;
      StEditMin: return FieldMin;
      StEditSec: return FieldSec;
      default:   return FieldNone;
    endcase
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Combinational +/-1 on a two-digit BCD field with wrap between 00 and max.
module bcd_field_step
  import time_pkg::*;
(
  input  logic [7:0] value,
  input  logic [7:0] max,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] result
);

  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] units;

  assign tens  = value[DIGIT_W +: DIGIT_W];
  assign units = value[0 +: DIGIT_W];

  always_comb begin
    result = value;
    if (inc && !dec) begin
      if (value == max)        result = 8'h00;
      else if (units == 4'd9)  result = {tens + 4'd1, 4'd0};
      else                     result = {tens, units + 4'd1};
    end else if (dec && !inc) begin
      if (value == 8'h00)      result = max;
      else if (units == 4'd0)  result = {tens - 4'd1, 4'd9};
      else                     result = {tens, units - 4'd1};
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Front-panel time-entry FSM: edits a BCD time word and strobes it into the clock core.
// Optional blinking of the selected field is enabled with `define TIME_SET_BLINK_EN.
module time_set_controller
  import time_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 24
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] cur_time,
  output logic [23:0] time_out,
  output logic        set_pulse,
  output logic        editing,
  output logic [1:0]  field,
  output logic [5:0]  blink_mask
);

  if (BLINK_DIV < 2) begin : g_div_check
    $error("BLINK_DIV must be at least 2");
  end

  state_e      state_q, state_d;
  logic [23:0] time_q, time_d;
  logic        mode_q, inc_q, dec_q;
  logic        rise_mode, rise_inc, rise_dec;
  field_e      sel_field;
  logic [7:0]  sel_val, sel_max, step_val;
  logic [5:0]  field_mask;
  logic        blink_on;

  assign rise_mode = btn_mode & ~mode_q;
  assign rise_inc  = btn_inc & ~inc_q;
  assign rise_dec  = btn_dec & ~dec_q;
  assign sel_field = state_field(state_q);

  always_comb begin
    sel_val = time_q[SEC_LSB +: 8];
    sel_max = MS_MAX;
    unique case (sel_field)
      FieldHr: begin
        sel_val = time_q[HR_LSB +: 8];
        sel_max = HR_MAX;
      end
      FieldMin: sel_val = time_q[MIN_LSB +: 8];
      default:  ;
    endcase
  end

  bcd_field_step u_step (
    .value  (sel_val),
    .max    (sel_max),
    .inc    (rise_inc),
    .dec    (rise_dec),
    .result (step_val)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    unique case (state_q)
      StIdle: begin
        if (rise_mode) begin
          time_d  = cur_time;
          state_d = StEditHr;
        end
      end
      StEditHr:  if (rise_mode) state_d = StEditMin;
      StEditMin: if (rise_mode) state_d = StEditSec;
      StEditSec: if (rise_mode) state_d = StCommit;
      StCommit:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // Mode wins over a coincident step; step_val equals sel_val when no step applies.
    if (!rise_mode) begin
      unique case (sel_field)
        FieldHr:  time_d[HR_LSB +: 8]  = step_val;
        FieldMin: time_d[MIN_LSB +: 8] = step_val;
        FieldSec: time_d[SEC_LSB +: 8] = step_val;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= StIdle;
      time_q  <= 24'h000000;
      mode_q  <= 1'b1;
      inc_q   <= 1'b1;
      dec_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
      dec_q   <= btn_dec;
    end
  end

`ifdef TIME_SET_BLINK_EN
  logic [BLINK_DIV-1:0] blink_q;

  always_ff @(posedge CLK) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_q + BLINK_DIV'(1);
  end

  assign blink_on = blink_q[BLINK_DIV-1];
`else
  assign blink_on = 1'b1;
`endif

  always_comb begin
    field_mask = 6'b000000;
    unique case (sel_field)
      FieldHr:  field_mask = 6'b110000;
      FieldMin: field_mask = 6'b001100;
      FieldSec: field_mask = 6'b000011;
      default:  ;
    endcase
  end

  assign time_out   = time_q;
  assign set_pulse  = (state_q == StCommit);
  assign editing    = (sel_field != FieldNone);
  assign field      = sel_field;
  assign blink_mask = blink_on ? field_mask : 6'b000000;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with a scoreboard of expected output snapshots.
module tb_time_set_controller;

  logic        CLK = 1'b0;
  logic        reset;
  logic        btn_mode, btn_inc, btn_dec;
  logic [23:0] cur_time;
  logic [23:0] time_out;
  logic        set_pulse, editing;
  logic [1:0]  field;
  logic [5:0]  blink_mask;

  always #5 CLK = ~CLK;

  time_set_controller dut (
    .CLK        (CLK),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .cur_time   (cur_time),
    .time_out   (time_out),
    .set_pulse  (set_pulse),
    .editing    (editing),
    .field      (field),
    .blink_mask (blink_mask)
  );

  typedef struct {
    string       tag;
    logic [23:0] t;
    logic        sp;
    logic        ed;
    logic [1:0]  fld;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // The blink counter MSB stays low for the whole run when blinking is built in.
  function automatic logic [5:0] mask_of(logic [1:0] f);
`ifdef TIME_SET_BLINK_EN
    return 6'b000000;
`else
    case (f)
      2'd0:    return 6'b110000;
      2'd1:    return 6'b001100;
      2'd2:    return 6'b000011;
      default: return 6'b000000;
    endcase
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(string tag, logic [23:0] t, logic sp, logic ed, logic [1:0] fld);
    exp_t e;
    e.tag = tag;
    e.t   = t;
    e.sp  = sp;
    e.ed  = ed;
    e.fld = fld;
    sb.push_back(e);
  endtask

  task automatic chk(string tag, string sig, logic [23:0] obs, logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, sig, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "time_out", time_out, e.t);
    chk(e.tag, "set_pulse", 24'(set_pulse), 24'(e.sp));
    chk(e.tag, "editing", 24'(editing), 24'(e.ed));
    chk(e.tag, "field", 24'(field), 24'(e.fld));
    chk(e.tag, "blink_mask", 24'(blink_mask), 24'(e.ed ? mask_of(e.fld) : 6'b000000));
  endtask

  // One button action: press, check the cycle after the detecting edge, release.
  task automatic act(string tag, logic m, logic i, logic d,
                     logic [23:0] t, logic sp, logic ed, logic [1:0] fld);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    push(tag, t, sp, ed, fld);
    tick();
    compare();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    tick();
  endtask

  task automatic idle_check(string tag, logic [23:0] t);
    push(tag, t, 1'b0, 1'b0, 2'd3);
    compare();
  endtask

  initial begin
    reset    = 1'b1;
    btn_mode = 1'b1;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    cur_time = 24'h000000;

    // Reset with mode held high, then no edge after release.
    tick();
    tick();
    idle_check("reset", 24'h000000);
    reset = 1'b0;
    tick();
    idle_check("held_mode_1", 24'h000000);
    tick();
    idle_check("held_mode_2", 24'h000000);
    btn_mode = 1'b0;
    tick();
    idle_check("mode_release", 24'h000000);

    // Enter and wrap hours, minute step, commit.
    cur_time = 24'h235955;
    act("enter_hr",   1, 0, 0, 24'h235955, 0, 1, 2'd0);
    act("hr_wrap_up", 0, 1, 0, 24'h005955, 0, 1, 2'd0);
    act("hr_wrap_dn", 0, 0, 1, 24'h235955, 0, 1, 2'd0);
    act("to_min",     1, 0, 0, 24'h235955, 0, 1, 2'd1);
    act("min_dec",    0, 0, 1, 24'h235855, 0, 1, 2'd1);
    act("to_sec",     1, 0, 0, 24'h235855, 0, 1, 2'd2);
    act("commit_a",   1, 0, 0, 24'h235855, 1, 0, 2'd3);
    idle_check("idle_a", 24'h235855);

    // Minute borrow wrap with neighbours untouched.
    cur_time = 24'h120000;
    act("enter_b",    1, 0, 0, 24'h120000, 0, 1, 2'd0);
    act("to_min_b",   1, 0, 0, 24'h120000, 0, 1, 2'd1);
    act("min_borrow", 0, 0, 1, 24'h125900, 0, 1, 2'd1);
    act("to_sec_b",   1, 0, 0, 24'h125900, 0, 1, 2'd2);
    act("commit_b",   1, 0, 0, 24'h125900, 1, 0, 2'd3);
    idle_check("idle_b", 24'h125900);

    // Seconds carry, borrow, wrap and simultaneous events.
    cur_time = 24'h120009;
    act("enter_c",    1, 0, 0, 24'h120009, 0, 1, 2'd0);
    act("to_min_c",   1, 0, 0, 24'h120009, 0, 1, 2'd1);
    act("to_sec_c",   1, 0, 0, 24'h120009, 0, 1, 2'd2);
    act("sec_carry",  0, 1, 0, 24'h120010, 0, 1, 2'd2);
    act("sec_borrow", 0, 0, 1, 24'h120009, 0, 1, 2'd2);
    for (int k = 8; k >= 0; k--) begin
      act("sec_dec", 0, 0, 1, {20'h12000, 4'(k)}, 0, 1, 2'd2);
    end
    act("sec_wrap_dn", 0, 0, 1, 24'h120059, 0, 1, 2'd2);
    act("sec_wrap_up", 0, 1, 0, 24'h120000, 0, 1, 2'd2);
    act("inc_and_dec", 0, 1, 1, 24'h120000, 0, 1, 2'd2);
    act("mode_wins",   1, 1, 0, 24'h120000, 1, 0, 2'd3);
    idle_check("idle_c", 24'h120000);
    act("idle_inc",    0, 1, 0, 24'h120000, 0, 0, 2'd3);
    act("idle_dec",    0, 0, 1, 24'h120000, 0, 0, 2'd3);

    // Hours units carry/borrow, then abort by reset in the minutes field.
    cur_time = 24'h091530;
    act("enter_d",    1, 0, 0, 24'h091530, 0, 1, 2'd0);
    act("hr_carry",   0, 1, 0, 24'h101530, 0, 1, 2'd0);
    act("hr_borrow",  0, 0, 1, 24'h091530, 0, 1, 2'd0);
    act("to_min_d",   1, 0, 0, 24'h091530, 0, 1, 2'd1);
    reset    = 1'b1;
    btn_inc  = 1'b1;
    btn_mode = 1'b1;
    push("abort", 24'h000000, 0, 0, 2'd3);
    tick();
    compare();
    reset    = 1'b0;
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    tick();
    idle_check("after_abort", 24'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
